// File: rtl/framer_pkg.sv
// Shared types for the response framer: FSM states and the
// {code,data} record carried through the FIFO.
package framer_pkg;

  localparam int FRAME_BYTES = 2;
  localparam int REC_W       = 8 * FRAME_BYTES;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND_CODE = 3'd1,
    S_WAIT_CODE = 3'd2,
    S_SEND_DATA = 3'd3,
    S_WAIT_DATA = 3'd4
  } state_e;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] data;
  } rec_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous record FIFO; pointers carry one extra wrap bit
// so full and empty are distinguishable.
module resp_fifo
  import framer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [REC_W-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [REC_W-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count = wr_q - rd_q;
  assign dout  = mem_q[rd_q[AW-1:0]];

  // a pop frees the slot, so a push on a full FIFO still lands
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + (AW+1)'(do_push);
    rd_d    = rd_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/response_framer.sv
// Queues result records and sends each as a code byte then a
// data byte to the UART transmitter, with per-byte timeout.
module response_framer
  import framer_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Resp_Valid,
  input  logic [7:0] i_Resp_Code,
  input  logic [7:0] i_Resp_Data,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  output logic       o_Busy,
  output logic       o_Overrun,
  output logic       o_Tx_Error,
  output logic [7:0] o_Drop_Count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             dv_q, dv_d;
  logic [7:0]       byte_q, byte_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic             err_q, err_d;
  logic [7:0]       drop_q, drop_d;

  logic             pop;
  logic             push_ok;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] fifo_dout;
  logic [AW:0]      fifo_count;
  logic [AW:0]      count_nx;
  rec_t             head;

  assign head = rec_t'(fifo_dout);

  resp_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (i_Clock),
    .rst  (i_Reset),
    .push (i_Resp_Valid),
    .pop  (pop),
    .din  ({i_Resp_Code, i_Resp_Data}),
    .full (fifo_full),
    .empty(fifo_empty),
    .dout (fifo_dout),
    .count(fifo_count)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    ovr_d   = ovr_q;
    err_d   = err_q;
    drop_d  = drop_q;
    pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !i_Tx_Active) begin
          pop     = 1'b1;
          data_d  = head.data;
          byte_d  = head.code;
          dv_d    = 1'b1;
          state_d = S_SEND_CODE;
        end
      end
      S_SEND_CODE: begin
        tmo_d   = '0;
        state_d = S_WAIT_CODE;
      end
      S_WAIT_CODE: begin
        if (i_Tx_Done) begin
          byte_d  = data_q;
          dv_d    = 1'b1;
          state_d = S_SEND_DATA;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_SEND_DATA: begin
        tmo_d   = '0;
        state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (i_Tx_Done) begin
          state_d = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    push_ok = i_Resp_Valid && (!fifo_full || pop);
    if (i_Resp_Valid && !push_ok) begin
      ovr_d = 1'b1;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end

    // busy is registered from next-cycle occupancy and state
    count_nx = fifo_count + (AW+1)'(push_ok) - (AW+1)'(pop);
    busy_d   = (state_d != S_IDLE) || (count_nx != '0);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      data_q  <= 8'h00;
      tmo_q   <= '0;
      dv_q    <= 1'b0;
      byte_q  <= 8'h00;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign o_Tx_DV      = dv_q;
  assign o_Tx_Byte    = byte_q;
  assign o_Busy       = busy_q;
  assign o_Overrun    = ovr_q;
  assign o_Tx_Error   = err_q;
  assign o_Drop_Count = drop_q;

endmodule

// File: doc/response_framer.md
# response_framer

Buffers result records from the sensor interface stage and serialises each into a two-byte UART frame (code byte, then data byte) for the UART TX stage. It sits between the interface's done/data outputs and the transmitter's i_Tx_DV/i_Tx_Byte inputs. It absorbs single-cycle result pulses that have no back-pressure, sequences byte-by-byte against o_Tx_Done, and reports drops and stalled transmissions.

## Interface
- FIFO_DEPTH, 4: record FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 100000: maximum wait for i_Tx_Done per byte. One byte at 9600 baud from 50 MHz is 52080 cycles.
- i_Clock  in  1  system clock, 50 MHz.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Resp_Valid  in  1  single-cycle pulse; record present on i_Resp_Code/i_Resp_Data.
- i_Resp_Code  in  8  response/status code; sent first.
- i_Resp_Data  in  8  measurement byte; sent second.
- i_Tx_Active  in  1  UART TX busy.
- i_Tx_Done  in  1  UART TX single-cycle byte-complete pulse.
- o_Tx_DV  out  1  single-cycle start strobe to UART TX.
- o_Tx_Byte  out  8  byte to transmit; held stable from strobe until done or abort.
- o_Busy  out  1  high when FSM is not IDLE or FIFO is non-empty.
- o_Overrun  out  1  sticky; a record was dropped on a full FIFO.
- o_Tx_Error  out  1  sticky; a byte wait timed out.
- o_Drop_Count  out  8  count of dropped records; saturates at 255.

## Operation
- FIFO push on i_Resp_Valid. The push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
- If a push is refused, the record is discarded, o_Overrun is set, and o_Drop_Count increments (saturating).
- A simultaneous push and pop leaves the occupancy unchanged.
- FSM states: IDLE, SEND_CODE, WAIT_CODE, SEND_DATA, WAIT_DATA.
- IDLE: if FIFO is non-empty and i_Tx_Active=0, pop the head into the frame register and go to SEND_CODE. Otherwise stay.
- SEND_CODE: o_Tx_DV=1 for exactly this cycle, o_Tx_Byte=code, clear the timeout counter, go to WAIT_CODE.
- WAIT_CODE: on i_Tx_Done, go to SEND_DATA. An i_Tx_Done arriving in any other state is ignored.
- SEND_DATA: o_Tx_DV=1 for this cycle, o_Tx_Byte=data, clear the timeout counter, go to WAIT_DATA.
- WAIT_DATA: on i_Tx_Done, go to IDLE.
- Timeout: in either WAIT state, the counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 without i_Tx_Done:
  - set o_Tx_Error;
  - abandon the rest of the frame and go to IDLE;
  - the record is not retried.
- If i_Tx_Done and timeout coincide, done wins.
- o_Overrun, o_Tx_Error and o_Drop_Count clear only on reset.
- Counter width: $clog2(TIMEOUT_CYCLES).

## Timing
- Reset values: o_Tx_DV=0, o_Tx_Byte=8'h00, o_Busy=0, o_Overrun=0, o_Tx_Error=0, o_Drop_Count=0. FSM=IDLE, FIFO empty.
- Reset mid-frame: the FIFO is flushed and any partial frame is lost. No strobe is issued in the cycle after deassertion.
- Latency, empty FIFO and idle TX: i_Resp_Valid in cycle N gives the pop at the N+1 edge and o_Tx_DV=1 in cycle N+2.
- Data strobe: i_Tx_Done in cycle M during WAIT_CODE gives the data strobe in cycle M+1.
- Next frame: i_Tx_Done in WAIT_DATA at cycle M gives IDLE at M+1; the next code strobe comes no earlier than M+2, and only with i_Tx_Active=0.
- All outputs are registered.

## Structure
- Shared package framer_pkg:
  - state enum localparams (3-bit);
  - FRAME_BYTES=2;
  - record width 16 ({code,data}).
- One sub-module: resp_fifo.
  - Synchronous FIFO, FIFO_DEPTH x 16 bits.
  - Ports: push, pop, full, empty, dout.
  - Pointers are one bit wider than the address for full/empty detection.
- response_framer holds the FSM, timeout counter and status flags.

## Test plan
- Single record 0x01/0x1A; model TX asserts done 20 cycles after each strobe:
  - strobe with byte 0x01 at cycle N+2;
  - strobe with byte 0x1A one cycle after the first done;
  - o_Busy falls one cycle after the second done.
- FIFO_DEPTH=4 with TX stalled (i_Tx_Active=1): push 6 records in consecutive cycles.
  - 4 records stored;
  - o_Overrun=1, o_Drop_Count=2;
  - after release, exactly 8 bytes sent, in order.
- Push exactly when FIFO is full and IDLE pops in the same cycle: the record is accepted and o_Drop_Count is unchanged.
- TX never returns done after the code strobe, TIMEOUT_CYCLES=100:
  - o_Tx_Error=1 at 100 cycles;
  - no data strobe;
  - the next queued record's code strobe still follows.
- Spurious i_Tx_Done in IDLE and SEND states: no state change and no extra strobes.
- Assert i_Reset during WAIT_DATA with 2 records queued: all outputs return to reset values and no strobe occurs after release.
